// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive-side decoder for the 8-digit multiplexed 7-segment scan bus.
//   It rebuilds HH-MM-SS frames from the active-low digit strobe and segment
//   pattern, checks their format and range, and commits binary time once a
//   frame has repeated STABLE_FRAMES times.
// Ports:
//   clk_5k      scan clock
//   rst         synchronous reset, active-high
//   digit[7:0]  active-low one-hot digit select (bit k low = position k)
//   seg[6:0]    active-low segments, bit6 = a ... bit0 = g
//   sec/min     committed seconds/minutes, binary 0-59
//   hour        committed hours, binary 0-23
//   time_valid  one-cycle pulse on (re)commit
//   frame_err   one-cycle pulse on frame abort
//   locked      high after a commit, cleared by frame_err or rst
module seg_scan_decoder #(
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic       clk_5k,
  input  logic       rst,
  input  logic [7:0] digit,
  input  logic [6:0] seg,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic       time_valid,
  output logic       frame_err,
  output logic       locked
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_FRAMES);

  typedef enum logic {HUNT, COLLECT} state_t;

  state_t     state;
  logic [7:0] digit_q, digit_prev;
  logic [6:0] seg_q;
  logic [2:0] exp;
  logic [3:0] match_cnt;
  logic [3:0] s_one, s_ten, m_one, m_ten, h_one;
  logic [5:0] prev_sec, prev_min;
  logic [4:0] prev_hour;

  logic [7:0] sel;
  logic       new_sample, onehot, is_digit, is_dash, glyph_ok, start_ok, range_ok;
  logic [2:0] pos;
  logic [3:0] gval;
  logic [5:0] f_sec, f_min;
  logic [4:0] f_hour;
  logic       restart_cnt, commit;
  logic [3:0] cnt_next;

  always_comb begin
    sel        = ~digit_q;
    new_sample = (digit_q != digit_prev);
    onehot     = (sel != '0) && ((sel & (sel - 8'd1)) == '0);
    pos        = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (sel[i]) pos = 3'(i);
    end

    is_digit = 1'b1;
    is_dash  = 1'b0;
    gval     = '0;
    case (seg_q)
      7'b0000001: gval = 4'd0;
      7'b1001111: gval = 4'd1;
      7'b0010010: gval = 4'd2;
      7'b0000110: gval = 4'd3;
      7'b1001100: gval = 4'd4;
      7'b0100100: gval = 4'd5;
      7'b0100000: gval = 4'd6;
      7'b0001111: gval = 4'd7;
      7'b0000000: gval = 4'd8;
      7'b0000100: gval = 4'd9;
      7'b1111110: begin
        is_digit = 1'b0;
        is_dash  = 1'b1;
      end
      default: is_digit = 1'b0;
    endcase

    glyph_ok = ((pos == 3'd2) || (pos == 3'd5)) ? is_dash : is_digit;
    start_ok = onehot && (pos == 3'd0) && is_digit;

    // Only meaningful on the position-7 sample, where gval is hour tens.
    range_ok = (s_ten <= 4'd5) && (m_ten <= 4'd5) && (gval <= 4'd2) &&
               !((gval == 4'd2) && (h_one > 4'd3));
    f_sec  = {2'b00, s_ten} * 6'd10 + {2'b00, s_one};
    f_min  = {2'b00, m_ten} * 6'd10 + {2'b00, m_one};
    f_hour = {1'b0, gval} * 5'd10 + {1'b0, h_one};

    // A zero count marks the first good frame after reset or an abort.
    restart_cnt = (match_cnt == '0) || (f_sec != prev_sec) ||
                  (f_min != prev_min) || (f_hour != prev_hour);
    if (restart_cnt)                cnt_next = 4'd1;
    else if (match_cnt < STABLE_N)  cnt_next = match_cnt + 4'd1;
    else                            cnt_next = match_cnt;
    // Saturated identical frames must not re-commit.
    commit = (cnt_next == STABLE_N) && (restart_cnt || (match_cnt < STABLE_N));
  end

  always_ff @(posedge clk_5k) begin
    if (rst) begin
      digit_q    <= '1;
      digit_prev <= '1;
      seg_q      <= '1;
      state      <= HUNT;
      exp        <= '0;
      match_cnt  <= '0;
      s_one      <= '0;
      s_ten      <= '0;
      m_one      <= '0;
      m_ten      <= '0;
      h_one      <= '0;
      prev_sec   <= '0;
      prev_min   <= '0;
      prev_hour  <= '0;
      sec        <= '0;
      min        <= '0;
      hour       <= '0;
      time_valid <= 1'b0;
      frame_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      digit_q    <= digit;
      seg_q      <= seg;
      digit_prev <= digit_q;
      time_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (new_sample) begin
        case (state)
          HUNT: begin
            if (start_ok) begin
              s_one <= gval;
              exp   <= 3'd1;
              state <= COLLECT;
            end
          end
          COLLECT: begin
            if (!onehot || (pos != exp) || !glyph_ok) begin
              frame_err <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
              // A valid position 0 arriving early starts the next frame at once.
              if (start_ok) begin
                s_one <= gval;
                exp   <= 3'd1;
                state <= COLLECT;
              end else begin
                exp   <= '0;
                state <= HUNT;
              end
            end else begin
              case (pos)
                3'd0:    s_one <= gval;
                3'd1:    s_ten <= gval;
                3'd3:    m_one <= gval;
                3'd4:    m_ten <= gval;
                3'd6:    h_one <= gval;
                default: ;
              endcase
              exp <= exp + 3'd1;
              if (pos == 3'd7) begin
                if (!range_ok) begin
                  frame_err <= 1'b1;
                  locked    <= 1'b0;
                  match_cnt <= '0;
                  exp       <= '0;
                  state     <= HUNT;
                end else begin
                  prev_sec  <= f_sec;
                  prev_min  <= f_min;
                  prev_hour <= f_hour;
                  match_cnt <= cnt_next;
                  if (commit) begin
                    sec        <= f_sec;
                    min        <= f_min;
                    hour       <= f_hour;
                    time_valid <= 1'b1;
                    locked     <= 1'b1;
                  end
                end
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
